// File: rtl/ipu_scan_controller_if.sv
// rtl/ipu_scan_controller_if.sv - control, line-buffer loader and convolution request signals of the scan controller
interface ipu_scan_controller_if #(
  parameter int COORD_W = 9,
  parameter int WADDR_W = 7
);
  logic                       start;
  logic [1:0]                 size;
  logic                       abort;
  logic                       mem_grant;
  logic                       conv_done;
  logic [COORD_W+WADDR_W-1:0] mem_addr;
  logic                       buf_load;
  logic [COORD_W-1:0]         buf_h;
  logic [COORD_W-1:0]         buf_v;
  logic                       conv_req;
  logic [COORD_W-1:0]         conv_x;
  logic [COORD_W-1:0]         conv_y;
  logic                       busy;
  logic                       done;

  modport master (
    input  start, size, abort, mem_grant, conv_done,
    output mem_addr, buf_load, buf_h, buf_v, conv_req, conv_x, conv_y, busy, done
  );

  modport slave (
    output start, size, abort, mem_grant, conv_done,
    input  mem_addr, buf_load, buf_h, buf_v, conv_req, conv_x, conv_y, busy, done
  );
endinterface

// File: rtl/ipu_scan_controller.sv
// rtl/ipu_scan_controller.sv - frame sequencer: line-buffer preload/row loads and raster convolution requests
module ipu_scan_controller #(
  parameter int IMG_W        = 512,
  parameter int IMG_H        = 480,
  parameter int PIX_PER_WORD = 4,
  parameter int COORD_W      = 9,
  parameter int WADDR_W      = 7,
  parameter int MAX_K        = 5
) (
  input logic                    clk,
  input logic                    reset,
  ipu_scan_controller_if.master  bus
);
  localparam int WPR      = IMG_W / PIX_PER_WORD;
  localparam int LOG2_PPW = $clog2(PIX_PER_WORD);
  localparam int KW       = $clog2(MAX_K);
  localparam logic [WADDR_W-1:0] W_LAST = WADDR_W'(WPR - 1);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);
  localparam logic [COORD_W:0]   H_LIM  = (COORD_W+1)'(IMG_H);

  typedef enum logic [2:0] {IDLE, PRELOAD, CONV, ROWLOAD, FINISH} state_t;

  state_t             state, state_nxt;
  logic               armed, armed_nxt;
  logic               gap, gap_nxt;
  logic [KW-1:0]      k_last, k_last_nxt;
  logic [COORD_W-1:0] v, v_nxt, x, x_nxt, y, y_nxt;
  logic [WADDR_W-1:0] w, w_nxt;
  logic [COORD_W:0]   new_row;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      armed  <= 1'b0;
      gap    <= 1'b0;
      k_last <= '0;
      v      <= '0;
      w      <= '0;
      x      <= '0;
      y      <= '0;
    end else begin
      state  <= state_nxt;
      armed  <= armed_nxt;
      gap    <= gap_nxt;
      k_last <= k_last_nxt;
      v      <= v_nxt;
      w      <= w_nxt;
      x      <= x_nxt;
      y      <= y_nxt;
    end
  end

  // Row that enters the kernel window once the current row y is finished.
  assign new_row = {1'b0, y} + (COORD_W+1)'(k_last) + (COORD_W+1)'(1);

  always_comb begin
    state_nxt  = state;
    armed_nxt  = armed;
    gap_nxt    = gap;
    k_last_nxt = k_last;
    v_nxt      = v;
    w_nxt      = w;
    x_nxt      = x;
    y_nxt      = y;
    if (state != IDLE && bus.abort) begin
      state_nxt = IDLE;
      gap_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Level start must be seen low before it can launch another frame.
          if (!bus.start) begin
            armed_nxt = 1'b1;
          end else if (armed) begin
            armed_nxt  = 1'b0;
            k_last_nxt = KW'(bus.size) + KW'(1);
            v_nxt      = '0;
            w_nxt      = '0;
            x_nxt      = '0;
            y_nxt      = '0;
            gap_nxt    = 1'b0;
            state_nxt  = PRELOAD;
          end
        end
        PRELOAD, ROWLOAD: begin
          if (bus.mem_grant) begin
            if (w == W_LAST) begin
              w_nxt = '0;
              if (state == ROWLOAD || v == COORD_W'(k_last)) begin
                state_nxt = CONV;
                gap_nxt   = 1'b0;
              end else begin
                v_nxt = v + COORD_W'(1);
              end
            end else begin
              w_nxt = w + WADDR_W'(1);
            end
          end
        end
        CONV: begin
          if (gap) begin
            gap_nxt = 1'b0;
          end else if (bus.conv_done) begin
            gap_nxt = 1'b1;
            if (x == X_LAST) begin
              if (y == Y_LAST) begin
                state_nxt = FINISH;
              end else begin
                x_nxt = '0;
                y_nxt = y + COORD_W'(1);
                // Near the bottom edge the window already holds every row needed.
                if (new_row < H_LIM) begin
                  state_nxt = ROWLOAD;
                  v_nxt     = new_row[COORD_W-1:0];
                  w_nxt     = '0;
                end
              end
            end else begin
              x_nxt = x + COORD_W'(1);
            end
          end
        end
        FINISH:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.buf_load = (state == PRELOAD || state == ROWLOAD) && bus.mem_grant;
  assign bus.mem_addr = {v, w};
  assign bus.buf_h    = COORD_W'(w) << LOG2_PPW;
  assign bus.buf_v    = v;
  assign bus.conv_req = (state == CONV) && !gap;
  assign bus.conv_x   = x;
  assign bus.conv_y   = y;
  assign bus.busy     = (state == PRELOAD) || (state == CONV) || (state == ROWLOAD);
  assign bus.done     = (state == FINISH);
endmodule

// File: tb/tb_ipu_scan_controller.sv
// tb/tb_ipu_scan_controller.sv - scoreboard bench for ipu_scan_controller on an 8x4 frame
module tb_ipu_scan_controller;
  localparam int IMG_W = 8, IMG_H = 4, PPW = 4, COORD_W = 9, WADDR_W = 1, MAX_K = 5;
  localparam int WPR = IMG_W / PPW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ipu_scan_controller_if #(.COORD_W(COORD_W), .WADDR_W(WADDR_W)) bus ();

  ipu_scan_controller #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_PER_WORD(PPW),
    .COORD_W(COORD_W), .WADDR_W(WADDR_W), .MAX_K(MAX_K)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0, failures = 0;
  logic [31:0] load_q[$];
  logic [31:0] req_q[$];
  int req_total = 0, done_cnt = 0, busy_cnt = 0, oob = 0;
  int resp_mode = 0;
  logic abort_armed = 1'b0;
  logic resp_done = 1'b0, late_done = 1'b0;
  logic prev_req = 1'b0;
  logic [31:0] prev_xy = '0, mon_xy;

  assign bus.conv_done = resp_done | late_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ld(input int rc, input int r, input int w);
    return {16'(rc), 6'd0, 10'(r * WPR + w)};
  endfunction

  function automatic logic [31:0] rq(input int x, input int y);
    return {7'd0, 9'(x), 7'd0, 9'(y)};
  endfunction

  // Monitor: pops the scoreboard on each load and each new request, and answers requests.
  always @(negedge clk) begin
    if (reset) begin
      prev_req  = 1'b0;
      resp_done = 1'b0;
    end else begin
      mon_xy = {7'd0, bus.conv_x, 7'd0, bus.conv_y};
      if (bus.buf_load) begin
        if (int'(bus.mem_addr >> WADDR_W) >= IMG_H) oob++;
        if (load_q.size() == 0) check("load_unexpected", {22'd0, bus.mem_addr}, 32'hffff_ffff);
        else check("load", {16'(req_total), 6'd0, bus.mem_addr}, load_q.pop_front());
      end
      if (bus.conv_req && !prev_req) begin
        if (req_q.size() == 0) check("req_unexpected", mon_xy, 32'hffff_ffff);
        else check("req", mon_xy, req_q.pop_front());
        req_total++;
      end else if (bus.conv_req && mon_xy != prev_xy) begin
        check("req_stable", mon_xy, prev_xy);
      end
      if (bus.done) done_cnt++;
      if (bus.busy) busy_cnt++;
      prev_req  = bus.conv_req;
      prev_xy   = mon_xy;
      resp_done = (resp_mode == 1) ||
                  (bus.conv_req && !(abort_armed && bus.conv_x == 9'd3 && bus.conv_y == 9'd1));
    end
  end

  task automatic push_exp(input int k, input int base, input int nreq);
    for (int r = 0; r < k; r++)
      for (int w = 0; w < WPR; w++) load_q.push_back(ld(base, r, w));
    for (int i = 0; i < nreq; i++) begin
      int x, y;
      x = i % IMG_W;
      y = i / IMG_W;
      req_q.push_back(rq(x, y));
      if (x == IMG_W - 1 && y < IMG_H - 1 && y + k < IMG_H && i + 1 < nreq)
        for (int w = 0; w < WPR; w++) load_q.push_back(ld(base + i + 1, y + k, w));
    end
  endtask

  task automatic run_frame(input int sz, input int stall_at, input int stall_len);
    int k, base, db, lat, d;
    k    = sz + 2;
    base = req_total;
    db   = done_cnt;
    lat  = 0;
    d    = 0;
    push_exp(k, base, IMG_W * IMG_H);
    bus.size  = 2'(sz);
    bus.start = 1'b1;
    for (int e = 1; e <= 200 && lat == 0; e++) begin
      @(posedge clk);
      #1 bus.mem_grant = !((e + 1) > stall_at && (e + 1) <= stall_at + stall_len);
      @(negedge clk);
      if ((e + 1) > stall_at && (e + 1) <= stall_at + stall_len) begin
        check("stall_load", {31'd0, bus.buf_load}, 32'd0);
        check("stall_addr", {22'd0, bus.mem_addr}, 32'd2);
      end
      if (bus.conv_req) lat = e;
    end
    check("first_req_latency", lat, 1 + k * WPR + stall_len);
    for (int c = 0; c < 1000 && d == 0; c++) begin
      @(negedge clk);
      if (bus.done) d = 1;
    end
    check("done_seen", d, 1);
    check("busy_at_done", {31'd0, bus.busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt - db, 1);
    check("busy_after", {31'd0, bus.busy}, 32'd0);
    check("load_q_empty", load_q.size(), 0);
    check("req_q_empty", req_q.size(), 0);
    check("req_count", req_total - base, IMG_W * IMG_H);
    check("no_oob_rows", oob, 0);
  endtask

  initial begin
    int bc, db, base, f;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.size      = 2'd0;
    bus.abort     = 1'b0;
    bus.mem_grant = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_conv_req", {31'd0, bus.conv_req}, 32'd0);
    check("rst_buf_load", {31'd0, bus.buf_load}, 32'd0);
    check("rst_mem_addr", {22'd0, bus.mem_addr}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // K=2 with row loads, then start held high: no second frame.
    run_frame(0, 0, 0);
    bc = busy_cnt;
    repeat (20) @(negedge clk);
    check("no_retrigger", busy_cnt - bc, 0);
    bus.start = 1'b0;
    @(negedge clk);

    // K=4: whole frame preloaded, no row loads.
    run_frame(2, 0, 0);
    bus.start = 1'b0;
    @(negedge clk);

    // conv_done held high: gap-cycle done must not advance x.
    resp_mode = 1;
    run_frame(0, 0, 0);
    resp_mode = 0;
    bus.start = 1'b0;
    @(negedge clk);

    // Grant dropped for 3 cycles mid-preload.
    run_frame(0, 3, 3);
    bus.start = 1'b0;
    @(negedge clk);

    // Abort at request (3,1), then a late conv_done.
    abort_armed = 1'b1;
    base = req_total;
    db   = done_cnt;
    push_exp(2, base, 12);
    bus.size  = 2'd0;
    bus.start = 1'b1;
    f = 0;
    for (int c = 0; c < 500 && f == 0; c++) begin
      @(negedge clk);
      if (bus.conv_req && bus.conv_x == 9'd3 && bus.conv_y == 9'd1) f = 1;
    end
    check("abort_target_seen", f, 1);
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    late_done = 1'b1;
    @(negedge clk);
    check("abort_conv_req", {31'd0, bus.conv_req}, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_buf_load", {31'd0, bus.buf_load}, 32'd0);
    @(posedge clk);
    #1 late_done = 1'b0;
    bc = busy_cnt;
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt - db, 0);
    check("abort_stays_idle", busy_cnt - bc, 0);
    check("abort_load_q", load_q.size(), 0);
    check("abort_req_q", req_q.size(), 0);
    abort_armed = 1'b0;
    bus.start   = 1'b0;
    @(negedge clk);
    run_frame(0, 0, 0);
    bus.start = 1'b0;
    @(negedge clk);

    // Asynchronous reset while stalled in the row-2 load.
    base = req_total;
    push_exp(2, base, IMG_W);
    load_q.push_back(ld(base + IMG_W, 2, 0));
    bus.size  = 2'd0;
    bus.start = 1'b1;
    f = 0;
    for (int c = 0; c < 500 && f == 0; c++) begin
      @(negedge clk);
      if (bus.buf_load && bus.mem_addr == 10'd4) f = 1;
    end
    check("rowload_seen", f, 1);
    @(posedge clk);
    #1 bus.mem_grant = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_conv_req", {31'd0, bus.conv_req}, 32'd0);
    check("arst_buf_load", {31'd0, bus.buf_load}, 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    check("arst_mem_addr", {22'd0, bus.mem_addr}, 32'd0);
    check("arst_buf_v", {23'd0, bus.buf_v}, 32'd0);
    check("arst_buf_h", {23'd0, bus.buf_h}, 32'd0);
    check("arst_conv_xy", {7'd0, bus.conv_x, 7'd0, bus.conv_y}, 32'd0);
    @(negedge clk);
    reset         = 1'b0;
    bus.mem_grant = 1'b1;
    check("arst_load_q", load_q.size(), 0);
    check("arst_req_q", req_q.size(), 0);
    bus.start = 1'b0;
    @(negedge clk);

    // K=3 frame after reset: one row load, then bottom-edge skip.
    run_frame(1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
